// File: rtl/interrupt_sequencer.sv
// 6502 reset/NMI/IRQ/BRK entry sequencer.
// Owns the datapath from an instruction boundary until the vector is loaded.
module interrupt_sequencer #(
  parameter logic [15:0] VEC_NMI = 16'hFFFA,
  parameter logic [15:0] VEC_RST = 16'hFFFC,
  parameter logic [15:0] VEC_IRQ = 16'hFFFE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        nmi_in,
  input  logic        irq_in,
  input  logic        i_flag,
  input  logic        brk_req,
  input  logic        boundary,
  output logic        seq_busy,
  output logic        push_en,
  output logic [1:0]  push_sel,
  output logic        pushed_b,
  output logic        mem_write,
  output logic        s_dec,
  output logic        vec_en,
  output logic [15:0] vec_addr,
  output logic        pcl_ld,
  output logic        pch_ld,
  output logic        set_i,
  output logic        seq_done,
  output logic [1:0]  active_src
);

  localparam logic [2:0] S_RST_HOLD = 3'd0;
  localparam logic [2:0] S_IDLE     = 3'd1;
  localparam logic [2:0] S_PUSH_H   = 3'd2;
  localparam logic [2:0] S_PUSH_L   = 3'd3;
  localparam logic [2:0] S_PUSH_P   = 3'd4;
  localparam logic [2:0] S_VEC_L    = 3'd5;
  localparam logic [2:0] S_VEC_H    = 3'd6;
  localparam logic [2:0] S_DONE     = 3'd7;

  localparam logic [1:0] SRC_NONE = 2'd0;
  localparam logic [1:0] SRC_RST  = 2'd1;
  localparam logic [1:0] SRC_NMI  = 2'd2;
  localparam logic [1:0] SRC_IRQ  = 2'd3;

  logic [2:0] state_q, state_d;
  logic [1:0] src_q, src_d;
  logic       pb_q, pb_d;
  logic       nmi_q, nmi_d;
  logic       nmi_pend_q, nmi_pend_d;
  logic       nmi_rearm_q, nmi_rearm_d;

  logic       nmi_edge;
  logic       accept;
  logic       take_nmi;
  logic       nmi_clr;
  logic       nmi_window;
  logic       is_int;
  logic [15:0] base;

  // Accept decision, source capture and next-state logic.
  always_comb begin
    nmi_edge = nmi_in & ~nmi_q;
    take_nmi = nmi_pend_q;
    accept   = (state_q == S_IDLE) & boundary &
               (nmi_pend_q | brk_req | (irq_in & ~i_flag));
    state_d  = state_q;
    src_d    = src_q;
    pb_d     = pb_q;
    unique case (state_q)
      S_RST_HOLD: begin
        state_d = S_PUSH_H;
        src_d   = SRC_RST;
        pb_d    = 1'b0;
      end
      S_IDLE: begin
        if (accept) begin
          state_d = S_PUSH_H;
          src_d   = take_nmi ? SRC_NMI : SRC_IRQ;
          pb_d    = brk_req;
        end
      end
      S_PUSH_H: state_d = S_PUSH_L;
      S_PUSH_L: state_d = S_PUSH_P;
      S_PUSH_P: state_d = S_VEC_L;
      S_VEC_L:  state_d = S_VEC_H;
      S_VEC_H:  state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
    endcase
  end

  // NMI edge tracking. The pending flag is consumed on entry to VEC_L;
  // an edge seen after the NMI was taken re-arms it so it is not lost.
  always_comb begin
    nmi_d      = nmi_in;
    nmi_clr    = (state_q == S_PUSH_P) & (src_q == SRC_NMI);
    nmi_window = ((state_q == S_IDLE) & accept & take_nmi) |
                 (((state_q == S_PUSH_H) | (state_q == S_PUSH_L) |
                   (state_q == S_PUSH_P)) & (src_q == SRC_NMI));
    nmi_rearm_d = ~nmi_clr & (nmi_rearm_q | (nmi_edge & nmi_window));
    nmi_pend_d  = nmi_edge | (nmi_pend_q & ~nmi_clr) |
                  (nmi_clr & nmi_rearm_q);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_RST_HOLD;
      src_q       <= SRC_RST;
      pb_q        <= 1'b0;
      nmi_q       <= nmi_in;
      nmi_pend_q  <= 1'b0;
      nmi_rearm_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      pb_q        <= pb_d;
      nmi_q       <= nmi_d;
      nmi_pend_q  <= nmi_pend_d;
      nmi_rearm_q <= nmi_rearm_d;
    end
  end

  // Micro-operation decode from the registered state and source.
  always_comb begin
    is_int     = (src_q != SRC_RST);
    base       = (src_q == SRC_NMI) ? VEC_NMI :
                 (src_q == SRC_RST) ? VEC_RST : VEC_IRQ;
    seq_busy   = 1'b1;
    push_en    = 1'b0;
    push_sel   = 2'd0;
    pushed_b   = 1'b0;
    mem_write  = 1'b0;
    s_dec      = 1'b0;
    vec_en     = 1'b0;
    vec_addr   = 16'h0000;
    pcl_ld     = 1'b0;
    pch_ld     = 1'b0;
    set_i      = 1'b0;
    seq_done   = 1'b0;
    active_src = src_q;
    unique case (state_q)
      S_RST_HOLD: active_src = SRC_RST;
      S_IDLE: begin
        seq_busy   = accept;
        active_src = SRC_NONE;
      end
      S_PUSH_H, S_PUSH_L, S_PUSH_P: begin
        s_dec     = 1'b1;
        push_en   = is_int;
        mem_write = is_int;
        push_sel  = (state_q == S_PUSH_H) ? 2'd0 :
                    (state_q == S_PUSH_L) ? 2'd1 : 2'd2;
        pushed_b  = is_int & pb_q & (state_q == S_PUSH_P);
      end
      S_VEC_L: begin
        vec_en   = 1'b1;
        vec_addr = base;
        pcl_ld   = 1'b1;
      end
      S_VEC_H: begin
        vec_en   = 1'b1;
        vec_addr = base + 16'd1;
        pch_ld   = 1'b1;
        set_i    = 1'b1;
      end
      S_DONE: begin
        seq_busy = 1'b0;
        seq_done = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Scoreboard bench for interrupt_sequencer.
// Stimulus queues expected per-cycle micro-ops; a monitor pops on activity.
module tb_interrupt_sequencer;

  logic        clk;
  logic        rst;
  logic        nmi_in;
  logic        irq_in;
  logic        i_flag;
  logic        brk_req;
  logic        boundary;
  logic        seq_busy;
  logic        push_en;
  logic [1:0]  push_sel;
  logic        pushed_b;
  logic        mem_write;
  logic        s_dec;
  logic        vec_en;
  logic [15:0] vec_addr;
  logic        pcl_ld;
  logic        pch_ld;
  logic        set_i;
  logic        seq_done;
  logic [1:0]  active_src;

  interrupt_sequencer dut (
    .clk(clk), .rst(rst), .nmi_in(nmi_in), .irq_in(irq_in),
    .i_flag(i_flag), .brk_req(brk_req), .boundary(boundary),
    .seq_busy(seq_busy), .push_en(push_en), .push_sel(push_sel),
    .pushed_b(pushed_b), .mem_write(mem_write), .s_dec(s_dec),
    .vec_en(vec_en), .vec_addr(vec_addr), .pcl_ld(pcl_ld),
    .pch_ld(pch_ld), .set_i(set_i), .seq_done(seq_done),
    .active_src(active_src)
  );

  typedef struct {
    int          cyc;
    logic [28:0] v;
    string       name;
  } exp_t;

  exp_t q[$];
  int   vectors    = 0;
  int   miscompares = 0;
  int   cyc        = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [28:0] pk(
    input logic pe, input logic [1:0] sel, input logic pb,
    input logic mw, input logic sd, input logic ve,
    input logic [15:0] va, input logic pl, input logic ph,
    input logic si, input logic dn, input logic [1:0] src);
    return {pe, sel, pb, mw, sd, ve, va, pl, ph, si, dn, src};
  endfunction

  logic [28:0] act;
  assign act = pk(push_en, push_sel, pushed_b, mem_write, s_dec,
                  vec_en, vec_addr, pcl_ld, pch_ld, set_i, seq_done,
                  active_src);

  // Queue the first n cycles of a sequence accepted in cycle k.
  task automatic exp_seq(input int k, input logic [1:0] src,
                         input logic pb, input logic [15:0] base,
                         input int n, input string tag);
    logic it;
    exp_t e;
    it = (src != 2'd1);
    for (int i = 1; i <= n; i++) begin
      e.cyc = k + i;
      case (i)
        1: e.v = pk(it, 2'd0, 1'b0, it, 1'b1, 1'b0, 16'h0,
                    1'b0, 1'b0, 1'b0, 1'b0, src);
        2: e.v = pk(it, 2'd1, 1'b0, it, 1'b1, 1'b0, 16'h0,
                    1'b0, 1'b0, 1'b0, 1'b0, src);
        3: e.v = pk(it, 2'd2, pb, it, 1'b1, 1'b0, 16'h0,
                    1'b0, 1'b0, 1'b0, 1'b0, src);
        4: e.v = pk(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, base,
                    1'b1, 1'b0, 1'b0, 1'b0, src);
        5: e.v = pk(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, base + 16'd1,
                    1'b0, 1'b1, 1'b1, 1'b0, src);
        default: e.v = pk(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0,
                          1'b0, 1'b0, 1'b0, 1'b1, src);
      endcase
      e.name = $sformatf("%s.%0d", tag, i);
      q.push_back(e);
    end
  endtask

  // Monitor: any cycle with a micro-op or done pulse consumes one entry.
  always @(negedge clk) begin
    exp_t e;
    if (push_en | mem_write | s_dec | vec_en | pcl_ld | pch_ld |
        set_i | seq_done) begin
      vectors++;
      if (q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_op cyc=%0d got=%h required=none",
                 cyc, act);
      end else begin
        e = q.pop_front();
        if (e.cyc != cyc || e.v !== act) begin
          miscompares++;
          $display("FAIL %s got cyc=%0d ops=%h required cyc=%0d ops=%h",
                   e.name, cyc, act, e.cyc, e.v);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h required=%h", name, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_reset(input string tag);
    @(negedge clk);
    chk({tag, "_busy"}, {31'd0, seq_busy}, 32'd1);
    chk({tag, "_src"}, {30'd0, active_src}, 32'd1);
    chk({tag, "_ops"}, {3'd0, act[28:2]}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; nmi_in = 1'b0; irq_in = 1'b0;
    i_flag = 1'b0; brk_req = 1'b0; boundary = 1'b0;
    tick(3);
    chk_reset("reset");
    tick();
    rst = 1'b0;
    exp_seq(cyc, 2'd1, 1'b0, 16'hFFFC, 6, "rst");
    tick(8);
    @(negedge clk);
    chk("idle_busy", {31'd0, seq_busy}, 32'd0);
    chk("idle_src", {30'd0, active_src}, 32'd0);

    tick();
    irq_in = 1'b1; boundary = 1'b1;
    exp_seq(cyc, 2'd3, 1'b0, 16'hFFFE, 6, "irq");
    tick();
    irq_in = 1'b0; boundary = 1'b0;
    tick(7);

    irq_in = 1'b1; i_flag = 1'b1; boundary = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("irq_masked_busy", {31'd0, seq_busy}, 32'd0);
      tick();
    end
    irq_in = 1'b0; i_flag = 1'b0; boundary = 1'b0;
    tick();

    brk_req = 1'b1; boundary = 1'b1;
    exp_seq(cyc, 2'd3, 1'b1, 16'hFFFE, 6, "brk");
    tick();
    brk_req = 1'b0; boundary = 1'b0;
    tick(7);

    nmi_in = 1'b1;
    tick();
    boundary = 1'b1;
    exp_seq(cyc, 2'd2, 1'b0, 16'hFFFA, 6, "nmi");
    tick();
    boundary = 1'b0;
    tick(6);
    boundary = 1'b1;
    tick(4);
    boundary = 1'b0;

    nmi_in = 1'b0;
    tick();
    nmi_in = 1'b1;
    tick();
    boundary = 1'b1;
    exp_seq(cyc, 2'd2, 1'b0, 16'hFFFA, 6, "nmi_a");
    tick();
    boundary = 1'b0; nmi_in = 1'b0;
    tick();
    nmi_in = 1'b1;
    tick(5);
    boundary = 1'b1;
    exp_seq(cyc, 2'd2, 1'b0, 16'hFFFA, 6, "nmi_b");
    tick();
    boundary = 1'b0;
    tick(7);
    boundary = 1'b1;
    tick(3);
    boundary = 1'b0;

    nmi_in = 1'b0;
    tick();
    nmi_in = 1'b1;
    tick();
    brk_req = 1'b1; boundary = 1'b1;
    exp_seq(cyc, 2'd2, 1'b1, 16'hFFFA, 6, "hijack");
    tick();
    brk_req = 1'b0; boundary = 1'b0;
    tick(6);
    boundary = 1'b1;
    tick(3);
    boundary = 1'b0;

    irq_in = 1'b1; boundary = 1'b1;
    exp_seq(cyc, 2'd3, 1'b0, 16'hFFFE, 3, "irq_abort");
    tick();
    irq_in = 1'b0; boundary = 1'b0;
    tick(2);
    rst = 1'b1;
    tick();
    chk_reset("abort");
    tick();
    rst = 1'b0;
    exp_seq(cyc, 2'd1, 1'b0, 16'hFFFC, 6, "rst2");
    tick(8);

    nmi_in = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    nmi_in = 1'b1;
    tick(2);
    rst = 1'b0;
    exp_seq(cyc, 2'd1, 1'b0, 16'hFFFC, 6, "rst3");
    tick(7);
    boundary = 1'b1;
    tick(4);
    boundary = 1'b0;
    tick(2);

    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL pending_expect got=%0d entries left required=0",
               q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/interrupt_sequencer.md
Name: interrupt_sequencer

Overview:
- Hardware sequencer for 6502 reset, NMI, IRQ and BRK entry. At an instruction boundary it takes the datapath away from the main control FSM.
- It drives the micro-operations that push PCH, PCL and P onto the stack, fetch the 16-bit vector into PC and set the I flag.
- The main control FSM stalls on seq_busy and resumes opcode fetch after seq_done.

Parameters:
- VEC_NMI, 16'hFFFA, NMI vector low-byte address.
- VEC_RST, 16'hFFFC, reset vector low-byte address.
- VEC_IRQ, 16'hFFFE, IRQ/BRK vector low-byte address.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- nmi_in  in  1  NMI request, active-high, rising-edge sensitive.
- irq_in  in  1  IRQ request, active-high, level sensitive.
- i_flag  in  1  current P[2] (interrupt disable).
- brk_req  in  1  one-cycle pulse from control when BRK is decoded; PC already points past the padding byte.
- boundary  in  1  control is at an instruction boundary and can be preempted this cycle.
- seq_busy  out  1  sequencer owns the datapath; control must hold.
- push_en  out  1  drive the selected register onto data_bus for a stack write.
- push_sel  out  2  0=PCH, 1=PCL, 2=P, 3=unused.
- pushed_b  out  1  B-bit value substituted into P on the P push.
- mem_write  out  1  memory write strobe (stack push).
- s_dec  out  1  decrement S at the end of this cycle.
- vec_en  out  1  drive vec_addr onto memory_bus_h/l.
- vec_addr  out  16  vector fetch address.
- pcl_ld  out  1  load PCL from data_bus.
- pch_ld  out  1  load PCH from data_bus.
- set_i  out  1  set P[2] at the end of this cycle.
- seq_done  out  1  one-cycle pulse; control resumes fetch next cycle.
- active_src  out  2  0=none, 1=reset, 2=NMI, 3=IRQ/BRK.

Behaviour:
- States: RST_HOLD, IDLE, PUSH_H, PUSH_L, PUSH_P, VEC_L, VEC_H, DONE.
- While rst=1:
  - state=RST_HOLD, seq_busy=1, active_src=1, all other outputs 0.
  - nmi_pend=0; nmi_q loads nmi_in, so an NMI held high through reset is not an edge.
- First cycle with rst=0: RST_HOLD -> PUSH_H with src=reset.
- Reset sequence: PUSH_H/L/P assert s_dec=1 only (push_en=0, mem_write=0), giving three dummy stack decrements. It then runs VEC_L/VEC_H at VEC_RST.
- NMI edge detect: nmi_q<=nmi_in every cycle. nmi_pend sets on nmi_in & ~nmi_q and clears in the cycle the sequence enters VEC_L with src=NMI. An edge arriving in that same cycle keeps nmi_pend set (set wins).
- Accept: in IDLE when boundary=1 and any of nmi_pend, brk_req, or (irq_in & ~i_flag) is true.
  - seq_busy goes high combinationally in the accept cycle.
  - Next state is PUSH_H.
- Priority: NMI > BRK > IRQ.
- BRK with NMI pending: NMI vector is used, pushed_b=1 (hijack), and brk_req is consumed.
- Otherwise pushed_b=1 for BRK and 0 for IRQ/NMI.
- Source and pushed_b are registered at accept and are held constant for the whole sequence.
- Interrupt push sequence (one cycle per state):
  - PUSH_H: push_en=1, push_sel=0, mem_write=1, s_dec=1.
  - PUSH_L: same, push_sel=1.
  - PUSH_P: same, push_sel=2.
- VEC_L: vec_en=1, vec_addr=base, pcl_ld=1.
- VEC_H: vec_en=1, vec_addr=base+1, pch_ld=1, set_i=1.
- DONE: seq_done=1, seq_busy=0, next state IDLE.
- vec_addr=0 outside VEC_L/VEC_H. seq_busy=1 in every state except IDLE and DONE.
- Latency: accept cycle N gives seq_done in cycle N+6. Back-to-back sequences need a new boundary after DONE.
- Inputs are sampled only at accept; irq_in or i_flag changes mid-sequence are ignored. The sequence is committed once accepted.
- brk_req outside an IDLE & boundary cycle is ignored; control must re-issue it.
- rst=1 in any state aborts immediately to RST_HOLD; outputs go to reset values in the following cycle.
- active_src=0 in IDLE; it holds the source from accept through DONE.

Test Plan:
- Reset release: rst 1->0 -> three cycles s_dec=1 with mem_write=0, then vec_addr=FFFC with pcl_ld, then FFFD with pch_ld and set_i; seq_done on the 6th cycle after release.
- IRQ: irq_in=1, i_flag=0, boundary pulse -> push_sel 0,1,2 with mem_write, pushed_b=0, vec FFFE/FFFF, seq_done at N+6. Repeat with i_flag=1 -> no accept, seq_busy=0.
- NMI edge: nmi_in rises and stays high -> exactly one sequence at vec FFFA. A second rise during PUSH_L -> a second sequence after the next boundary.
- BRK/NMI hijack: brk_req and nmi_pend both true at a boundary -> vec FFFA, pushed_b=1, and no separate BRK sequence afterwards.
- Reset mid-sequence: rst=1 during PUSH_P -> no further mem_write; after release a full reset sequence to FFFC.
- NMI held high through reset -> no NMI sequence after release.
